ram_port_driver: RTL and testbench
==================================

Name: ram_port_driver

Overview:
- Initiator/controller for the lab's 16x8 synchronous RAM: one write port (we, inaddr, din) and one registered read port (outaddr, dout), with a write taking priority over the read.
- Turns valid/ready user commands (single write, single read) and a scan request into correctly timed RAM port activity.
- Scan reads all addresses in order, for display or checksum logic.
- Owns the RAM's one-cycle read latency and the rule that dout is not updated in a write cycle.

Parameters:
- ADDR_W, 4, RAM address width; depth = 2**ADDR_W.
- DATA_W, 8, RAM data width.
- SCAN_HOLD, 0, idle cycles inserted after each scan rd_valid pulse before the next scan read is issued (0..255).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  controller can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  command address.
- cmd_data  in  DATA_W  write data.
- scan_start  in  1  one-cycle request to read all addresses 0..DEPTH-1.
- ram_we  out  1  to RAM we.
- ram_inaddr  out  ADDR_W  to RAM inaddr.
- ram_din  out  DATA_W  to RAM din.
- ram_outaddr  out  ADDR_W  to RAM outaddr.
- ram_dout  in  DATA_W  from RAM dout.
- rd_valid  out  1  one-cycle pulse; rd_addr and rd_data are valid.
- rd_addr  out  ADDR_W  address of the returned data.
- rd_data  out  DATA_W  returned data.
- busy  out  1  high in every state except IDLE.
- scan_done  out  1  one-cycle pulse coincident with the last scan rd_valid.
- verify_err  out  1  sticky write-verify mismatch flag (see Optional Feature).

Behaviour:
- All outputs are registered.
- Reset state: state = IDLE; every output = 0, except cmd_ready = 1 after reset is released.
- Reset asserted mid-operation aborts at once: ram_we drops asynchronously, no rd_valid, no scan_done.
- States: IDLE, WR, RD_ISSUE, RD_WAIT, SCAN_ISSUE, SCAN_WAIT, SCAN_GAP, plus VFY_ISSUE and VFY_WAIT when the optional feature is built in.
- cmd_ready = 1 only in IDLE.
- A command is accepted in the cycle where cmd_valid && cmd_ready. Call that cycle 0.
- IDLE arbitration: scan_start has priority over cmd_valid. A pending command stays pending because cmd_ready is low.
- scan_start is ignored outside IDLE; it is not queued.
- Write, accepted in cycle 0:
  - Cycle 1 (WR): ram_we = 1, ram_inaddr = cmd_addr, ram_din = cmd_data.
  - Cycle 2: IDLE, cmd_ready = 1.
  - ram_we is high for exactly one cycle per write.
- Read, accepted in cycle 0:
  - Cycle 1 (RD_ISSUE): ram_we = 0, ram_outaddr = cmd_addr. The RAM latches at the end of cycle 1.
  - Cycle 2 (RD_WAIT): ram_dout is valid and is captured at the end of cycle 2.
  - Cycle 3: rd_valid = 1, rd_addr = cmd_addr, rd_data = captured value, state IDLE, cmd_ready = 1.
- Scan, started in cycle 0:
  - Address counter starts at 0. Each address goes through ISSUE, WAIT, then a capture cycle with rd_valid, the same as a read.
  - After each rd_valid, SCAN_HOLD cycles are spent in SCAN_GAP; SCAN_GAP is skipped when SCAN_HOLD = 0.
  - With SCAN_HOLD = 0, rd_valid pulses occur every 2 cycles, in cycles 3, 5, ..., 33.
  - scan_done pulses with rd_valid for address DEPTH-1, then IDLE.
  - Counter wraps naturally; there is no extra read.
- ram_we is never asserted during read or scan states, so no RAM read is ever suppressed by a write.
- Address and data outputs hold their last values when not in use.
- rd_data/rd_addr hold between pulses.

Optional Feature:
- Macro: RAM_WRITE_VERIFY_EN.
- When defined, after WR the FSM goes to VFY_ISSUE and then VFY_WAIT:
  - VFY_ISSUE: ram_outaddr = the written address, ram_we = 0.
  - VFY_WAIT: ram_dout is compared to the written data in the following cycle.
  - On mismatch, verify_err is set to 1 and stays set until rst.
  - Return to IDLE; a write then occupies cycles 1-3 and cmd_ready returns in cycle 4.
  - Verify reads never pulse rd_valid.
- When not defined, verify_err is tied to 0 and write timing is as in Behaviour.

Test Plan:
- Reset, then write addr 3 = 8'hA5 → ram_we high exactly 1 cycle with inaddr = 3, din = A5; cmd_ready = 1 two cycles after acceptance.
- Read addr 3 after that write (RAM model attached) → rd_valid in cycle 3 with rd_addr = 3, rd_data = 8'hA5; ram_we = 0 throughout.
- Preload RAM with value = 8'h10 + addr, scan_start, SCAN_HOLD = 0 → 16 rd_valid pulses every 2 cycles carrying 10..1F in address order; scan_done on the 16th; cmd_ready low until then.
- scan_start and cmd_valid (read addr 7) in the same IDLE cycle → scan runs first; read of addr 7 is accepted on the first cycle back in IDLE.
- rst asserted in the middle of a scan (after address 5) → outputs 0 immediately, no scan_done; a following read of addr 0 completes normally.
- With RAM_WRITE_VERIFY_EN, RAM model forced to corrupt addr 9, write addr 9 = 8'h3C → verify_err rises and stays 1; no rd_valid pulse; cmd_ready returns in cycle 4.

Source files
------------

// File: rtl/ram_port_driver.sv
// ============================================================================
// Module   : ram_port_driver
// Purpose  : Command/scan controller for a synchronous RAM with one write
//            port and one registered read port. Owns the one-cycle read
//            latency and keeps writes out of read cycles.
// Options  : RAM_WRITE_VERIFY_EN - read back each write and flag mismatches
//            in a sticky verify_err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_port_driver #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int SCAN_HOLD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              scan_start,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_inaddr,
  output logic [DATA_W-1:0] ram_din,
  output logic [ADDR_W-1:0] ram_outaddr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              scan_done,
  output logic              verify_err
);

  localparam logic [3:0] c_st_idle       = 4'd0;
  localparam logic [3:0] c_st_wr         = 4'd1;
  localparam logic [3:0] c_st_rd_issue   = 4'd2;
  localparam logic [3:0] c_st_rd_wait    = 4'd3;
  localparam logic [3:0] c_st_scan_issue = 4'd4;
  localparam logic [3:0] c_st_scan_wait  = 4'd5;
  localparam logic [3:0] c_st_scan_gap   = 4'd6;
`ifdef RAM_WRITE_VERIFY_EN
  localparam logic [3:0] c_st_vfy_issue  = 4'd7;
  localparam logic [3:0] c_st_vfy_wait   = 4'd8;
`endif

  localparam logic [ADDR_W-1:0] c_last_addr = '1;
  // Last gap-counter value; only meaningful when SCAN_HOLD > 0.
  localparam logic [7:0]        c_hold_last = 8'(SCAN_HOLD - 1);

  logic [3:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [7:0]        gap_q, gap_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              busy_q, busy_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_inaddr_q, ram_inaddr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic [ADDR_W-1:0] ram_outaddr_q, ram_outaddr_d;
  logic              rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              scan_done_q, scan_done_d;
`ifdef RAM_WRITE_VERIFY_EN
  logic              verify_err_q, verify_err_d;
`endif

  // Next-state and registered-output computation for the port sequencer.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    gap_d         = gap_q;
    ram_we_d      = 1'b0;
    ram_inaddr_d  = ram_inaddr_q;
    ram_din_d     = ram_din_q;
    ram_outaddr_d = ram_outaddr_q;
    rd_valid_d    = 1'b0;
    rd_addr_d     = rd_addr_q;
    rd_data_d     = rd_data_q;
    scan_done_d   = 1'b0;
`ifdef RAM_WRITE_VERIFY_EN
    verify_err_d  = verify_err_q;
`endif
    case (state_q)
      c_st_idle: begin
        // Scan wins; a concurrent command waits because cmd_ready drops.
        if (scan_start) begin
          cnt_d         = '0;
          ram_outaddr_d = '0;
          state_d       = c_st_scan_issue;
        end else if (cmd_valid && cmd_ready_q) begin
          if (cmd_write) begin
            ram_we_d     = 1'b1;
            ram_inaddr_d = cmd_addr;
            ram_din_d    = cmd_data;
            state_d      = c_st_wr;
          end else begin
            ram_outaddr_d = cmd_addr;
            state_d       = c_st_rd_issue;
          end
        end
      end
      c_st_wr: begin
`ifdef RAM_WRITE_VERIFY_EN
        ram_outaddr_d = ram_inaddr_q;
        state_d       = c_st_vfy_issue;
`else
        state_d       = c_st_idle;
`endif
      end
      c_st_rd_issue: state_d = c_st_rd_wait;
      c_st_rd_wait: begin
        rd_valid_d = 1'b1;
        rd_addr_d  = ram_outaddr_q;
        rd_data_d  = ram_dout;
        state_d    = c_st_idle;
      end
      c_st_scan_issue: state_d = c_st_scan_wait;
      c_st_scan_wait: begin
        rd_valid_d = 1'b1;
        rd_addr_d  = ram_outaddr_q;
        rd_data_d  = ram_dout;
        if (cnt_q == c_last_addr) begin
          scan_done_d = 1'b1;
          state_d     = c_st_idle;
        end else if (SCAN_HOLD == 0) begin
          // Next address is issued in the same cycle rd_valid is presented.
          cnt_d         = cnt_q + 1'b1;
          ram_outaddr_d = cnt_q + 1'b1;
          state_d       = c_st_scan_issue;
        end else begin
          gap_d   = '0;
          state_d = c_st_scan_gap;
        end
      end
      c_st_scan_gap: begin
        if (gap_q == c_hold_last) begin
          cnt_d         = cnt_q + 1'b1;
          ram_outaddr_d = cnt_q + 1'b1;
          state_d       = c_st_scan_issue;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
`ifdef RAM_WRITE_VERIFY_EN
      c_st_vfy_issue: state_d = c_st_vfy_wait;
      c_st_vfy_wait: begin
        // ram_din still holds the written data, so it is the reference.
        if (ram_dout != ram_din_q) verify_err_d = 1'b1;
        state_d = c_st_idle;
      end
`endif
      default: state_d = c_st_idle;
    endcase
    cmd_ready_d = (state_d == c_st_idle);
    busy_d      = (state_d != c_st_idle);
  end

  // State and output registers; reset aborts any operation immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= c_st_idle;
      cnt_q         <= '0;
      gap_q         <= '0;
      cmd_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_inaddr_q  <= '0;
      ram_din_q     <= '0;
      ram_outaddr_q <= '0;
      rd_valid_q    <= 1'b0;
      rd_addr_q     <= '0;
      rd_data_q     <= '0;
      scan_done_q   <= 1'b0;
`ifdef RAM_WRITE_VERIFY_EN
      verify_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      ram_we_q      <= ram_we_d;
      ram_inaddr_q  <= ram_inaddr_d;
      ram_din_q     <= ram_din_d;
      ram_outaddr_q <= ram_outaddr_d;
      rd_valid_q    <= rd_valid_d;
      rd_addr_q     <= rd_addr_d;
      rd_data_q     <= rd_data_d;
      scan_done_q   <= scan_done_d;
`ifdef RAM_WRITE_VERIFY_EN
      verify_err_q  <= verify_err_d;
`endif
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign ram_we      = ram_we_q;
  assign ram_inaddr  = ram_inaddr_q;
  assign ram_din     = ram_din_q;
  assign ram_outaddr = ram_outaddr_q;
  assign rd_valid    = rd_valid_q;
  assign rd_addr     = rd_addr_q;
  assign rd_data     = rd_data_q;
  assign scan_done   = scan_done_q;
`ifdef RAM_WRITE_VERIFY_EN
  assign verify_err  = verify_err_q;
`else
  assign verify_err  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram_port_driver.sv
// ============================================================================
// Module   : tb_ram_port_driver
// Purpose  : Self-checking bench for ram_port_driver with an attached 16x8
//            synchronous RAM model and a reference memory image.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_port_driver;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              scan_start = 1'b0;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_inaddr;
  logic [DATA_W-1:0] ram_din;
  logic [ADDR_W-1:0] ram_outaddr;
  logic [DATA_W-1:0] ram_dout;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              scan_done;
  logic              verify_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference image of what the RAM should hold.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic              exp_verr = 1'b0;

  // RAM model controls.
  logic              corrupt_en = 1'b0;
  logic              preload    = 1'b0;
  logic [DATA_W-1:0] mem [DEPTH];

  always #5 clk = ~clk;

  ram_port_driver #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SCAN_HOLD(0)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .scan_start(scan_start),
    .ram_we(ram_we), .ram_inaddr(ram_inaddr), .ram_din(ram_din),
    .ram_outaddr(ram_outaddr), .ram_dout(ram_dout),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .scan_done(scan_done), .verify_err(verify_err)
  );

  // 16x8 synchronous RAM: write wins, dout not updated in a write cycle.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(8'h10 + i);
    end else if (ram_we) begin
      mem[ram_inaddr] <= (corrupt_en && ram_inaddr == 4'd9) ? (ram_din ^ 8'hFF) : ram_din;
    end else begin
      ram_dout <= mem[ram_outaddr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called right after a negedge; returns at a negedge with cmd_ready seen.
  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("wait_ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  // Cycles 1..3 after a read acceptance; current time is the cycle-1 negedge.
  task automatic read_tail(input logic [ADDR_W-1:0] a);
    check("rd_c1_outaddr", ram_outaddr, a);
    check("rd_c1_we", ram_we, 0);
    check("rd_c1_valid", rd_valid, 0);
    @(negedge clk);
    check("rd_c2_we", ram_we, 0);
    check("rd_c2_valid", rd_valid, 0);
    @(negedge clk);
    check("rd_c3_valid", rd_valid, 1);
    check("rd_c3_addr", rd_addr, a);
    check("rd_c3_data", rd_data, ref_mem[a]);
    check("rd_c3_ready", cmd_ready, 1);
    @(negedge clk);
    check("rd_pulse_end", rd_valid, 0);
    check("rd_data_hold", rd_data, ref_mem[a]);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a);
    wait_ready();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    read_tail(a);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wait_ready();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_data = d;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("wr_c1_we", ram_we, 1);
    check("wr_c1_inaddr", ram_inaddr, a);
    check("wr_c1_din", ram_din, d);
    check("wr_c1_ready", cmd_ready, 0);
    check("wr_c1_busy", busy, 1);
    ref_mem[a] = d;
`ifdef RAM_WRITE_VERIFY_EN
    @(negedge clk);
    check("wr_c2_we", ram_we, 0);
    check("wr_c2_ready", cmd_ready, 0);
    @(negedge clk);
    check("wr_c3_we", ram_we, 0);
    check("wr_c3_ready", cmd_ready, 0);
    check("wr_c3_valid", rd_valid, 0);
    @(negedge clk);
    check("wr_c4_ready", cmd_ready, 1);
    check("wr_c4_valid", rd_valid, 0);
`else
    @(negedge clk);
    check("wr_c2_we", ram_we, 0);
    check("wr_c2_ready", cmd_ready, 1);
    check("wr_c2_busy", busy, 0);
`endif
    check("wr_verr", verify_err, exp_verr);
  endtask

  // Observes a full scan; current time is the cycle-1 negedge after the start edge.
  // Pulses are expected at cycles 3,5,...,33 carrying addresses 0..15.
  task automatic scan_observe();
    int bad = 0;
    int pulses = 0;
    for (int c = 1; c <= 33; c++) begin
      if (c >= 3 && (c % 2) == 1) begin
        int k = (c - 3) / 2;
        check("scan_valid", rd_valid, 1);
        check("scan_addr", rd_addr, k);
        check("scan_data", rd_data, ref_mem[k]);
        check("scan_done", scan_done, (k == DEPTH - 1) ? 1 : 0);
        pulses++;
      end else if (rd_valid || scan_done) begin
        bad++;
      end
      if (ram_we) bad++;
      if (cmd_ready != (c == 33)) bad++;
      if (c < 33) @(negedge clk);
    end
    check("scan_timing_bad", bad, 0);
    check("scan_pulses", pulses, DEPTH);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_we", ram_we, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", scan_done, 0);
    check("rst_verr", verify_err, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", cmd_ready, 1);
    check("post_rst_busy", busy, 0);

    // Directed write then read of the same address.
    do_write(4'd3, 8'hA5);
    do_read(4'd3);

    // Preload RAM with 0x10 + addr.
    preload = 1'b1;
    @(posedge clk); #1 preload = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'(8'h10 + i);
    @(negedge clk);

    // Plain scan.
    wait_ready();
    scan_start = 1'b1;
    @(posedge clk); #1 scan_start = 1'b0;
    @(negedge clk);
    scan_observe();
    @(negedge clk);

    // Scan and read request in the same IDLE cycle: scan first, read after.
    wait_ready();
    scan_start = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd7;
    @(posedge clk); #1 scan_start = 1'b0;
    @(negedge clk);
    scan_observe();
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    read_tail(4'd7);

    // Reset in the middle of a scan, just after address 5 returned.
    wait_ready();
    scan_start = 1'b1;
    @(posedge clk); #1 scan_start = 1'b0;
    repeat (13) @(negedge clk);
    check("mid_scan_addr5", rd_addr, 5);
    check("mid_scan_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", rd_valid, 0);
    check("abort_done", scan_done, 0);
    check("abort_rdaddr", rd_addr, 0);
    check("abort_outaddr", ram_outaddr, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    begin
      int stray = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (rd_valid || scan_done || busy) stray++;
      end
      check("abort_no_stray", stray, 0);
    end
    do_read(4'd0);

    // Reset while ram_we is high: write is dropped before it lands.
    wait_ready();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd2; cmd_data = 8'hEE;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("wr_abort_we_before", ram_we, 1);
    #2 rst = 1'b1;
    #1 check("wr_abort_we_async", ram_we, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_read(4'd2);

    // Randomized command traffic against the reference image.
    for (int n = 0; n < 40; n++) begin
      logic [ADDR_W-1:0] a;
      a = ADDR_W'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 1) == 1) do_write(a, DATA_W'($urandom));
      else do_read(a);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

`ifdef RAM_WRITE_VERIFY_EN
    // Corrupted write at address 9 must raise a sticky verify error.
    corrupt_en = 1'b1;
    wait_ready();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd9; cmd_data = 8'h3C;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("vfy_c1_we", ram_we, 1);
    @(negedge clk);
    check("vfy_c2_outaddr", ram_outaddr, 9);
    check("vfy_c2_we", ram_we, 0);
    check("vfy_c2_valid", rd_valid, 0);
    @(negedge clk);
    check("vfy_c3_verr", verify_err, 0);
    check("vfy_c3_ready", cmd_ready, 0);
    check("vfy_c3_valid", rd_valid, 0);
    @(negedge clk);
    check("vfy_c4_verr", verify_err, 1);
    check("vfy_c4_ready", cmd_ready, 1);
    check("vfy_c4_valid", rd_valid, 0);
    corrupt_en = 1'b0;
    exp_verr = 1'b1;
    do_write(4'd4, 8'h55);
    do_read(4'd4);
    check("vfy_sticky", verify_err, 1);
`else
    check("verr_tied_low", verify_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule

`default_nettype wire
